// File: rtl/i2c_pkg.sv
// Shared constants and state encoding for the I2C three-byte word writer.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      BIT   = 3'd2,
      STOP  = 3'd3,
      DONE  = 3'd4
   } i2c_state_e;

   localparam int FRAME_SLOTS = 27;
   localparam int START_QP    = 2;
   localparam int STOP_QP     = 3;
   localparam logic [7:0] WM8731_WR_ADDR = 8'h34;

   localparam int         SLOTS_PER_BYTE = 9;
   localparam logic [3:0] ACK_SLOT       = 4'(SLOTS_PER_BYTE - 1);
   localparam logic [1:0] LAST_BYTE      = 2'(FRAME_SLOTS / SLOTS_PER_BYTE - 1);
   localparam logic [1:0] START_LAST_Q   = 2'(START_QP - 1);
   localparam logic [1:0] STOP_LAST_Q    = 2'(STOP_QP - 1);

   // Byte 0 (address) reports on the MSB of the nack vector.
   function automatic logic [1:0] nack_idx(input logic [1:0] byte_idx);
      return 2'd2 - byte_idx;
   endfunction

endpackage

// File: rtl/i2c_qphase_gen.sv
// Quarter-phase divider: strobes once per QUARTER_CYCLES clocks and tracks the quarter index.
module i2c_qphase_gen #(
   parameter int QUARTER_CYCLES = 1
) (
   input  logic       clk_i2c,
   input  logic       reset,
   input  logic       run_i,
   input  logic       last_i,
   output logic       strobe_o,
   output logic [1:0] quarter_o
);

   localparam logic [7:0] WRAP = 8'(QUARTER_CYCLES - 1);

   logic [7:0] div_q, div_d;
   logic [1:0] qtr_q, qtr_d;

   assign strobe_o  = run_i && (div_q == WRAP);
   assign quarter_o = qtr_q;

   // Held at zero while idle so every state entry starts on a fresh quarter.
   always_comb begin
      div_d = div_q;
      qtr_d = qtr_q;
      if (!run_i) begin
         div_d = '0;
         qtr_d = '0;
      end else if (strobe_o) begin
         div_d = '0;
         qtr_d = last_i ? 2'd0 : qtr_q + 2'd1;
      end else begin
         div_d = div_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i2c or posedge reset) begin
      if (reset) begin
         div_q <= '0;
         qtr_q <= '0;
      end else begin
         div_q <= div_d;
         qtr_q <= qtr_d;
      end
   end

endmodule

// File: rtl/i2c_word_writer.sv
// I2C master writing {slave_addr_rw, sub_addr, payload} as one 3-byte frame.
// Optional macro I2C_NACK_ABORT_EN: stop the frame after the first NACKed byte.
module i2c_word_writer
   import i2c_pkg::*;
#(
   parameter int QUARTER_CYCLES = 1
) (
   input  logic        clk_i2c,
   input  logic        reset,
   input  logic        go,
   input  logic [23:0] data,
   output logic        done,
   output logic        busy,
   output logic [2:0]  nack,
   output logic        i2c_sclk,
   inout  wire         i2c_sdat
);

   i2c_state_e  state_q, state_d;
   logic [23:0] shift_q, shift_d;
   logic [3:0]  bit_q, bit_d;
   logic [1:0]  byte_q, byte_d;
   logic [2:0]  nack_q, nack_d;

   logic       run, q_last, strobe, ack_slot, abort_now;
   logic [1:0] qtr;
   logic       scl, sda_low, sda_in;

   i2c_qphase_gen #(.QUARTER_CYCLES(QUARTER_CYCLES)) u_qphase (
      .clk_i2c   (clk_i2c),
      .reset     (reset),
      .run_i     (run),
      .last_i    (q_last),
      .strobe_o  (strobe),
      .quarter_o (qtr)
   );

   assign run      = (state_q == START) || (state_q == BIT) || (state_q == STOP);
   assign ack_slot = (bit_q == ACK_SLOT);
   assign sda_in   = i2c_sdat;
   assign i2c_sdat = sda_low ? 1'b0 : 1'bz;
   assign i2c_sclk = scl;
   assign done     = (state_q == DONE);
   assign busy     = run;
   assign nack     = nack_q;

`ifdef I2C_NACK_ABORT_EN
   assign abort_now = nack_q[nack_idx(byte_q)];
`else
   assign abort_now = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      nack_d  = nack_q;
      q_last  = 1'b0;
      scl     = 1'b1;
      sda_low = 1'b0;
      case (state_q)
         IDLE: begin
            if (go && !done) begin
               state_d = START;
               shift_d = data;
               nack_d  = '0;
               bit_d   = '0;
               byte_d  = '0;
            end
         end
         START: begin
            sda_low = 1'b1;
            scl     = (qtr == 2'd0);
            q_last  = (qtr == START_LAST_Q);
            if (strobe && q_last) state_d = BIT;
         end
         BIT: begin
            scl     = (qtr == 2'd1) || (qtr == 2'd2);
            sda_low = !ack_slot && !shift_q[23];
            if (strobe && ack_slot && (qtr == 2'd2) && sda_in)
               nack_d[nack_idx(byte_q)] = 1'b1;
            // Slot boundary: advance bit, then byte, then leave for STOP.
            if (strobe && (qtr == 2'd3)) begin
               if (!ack_slot) begin
                  shift_d = {shift_q[22:0], 1'b0};
                  bit_d   = bit_q + 4'd1;
               end else begin
                  bit_d = '0;
                  if ((byte_q == LAST_BYTE) || abort_now) state_d = STOP;
                  else                                     byte_d  = byte_q + 2'd1;
               end
            end
         end
         STOP: begin
            sda_low = (qtr != STOP_LAST_Q);
            scl     = (qtr != 2'd0);
            if (strobe && (qtr == STOP_LAST_Q)) state_d = DONE;
         end
         DONE: begin
            if (!go) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i2c or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         nack_q  <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         nack_q  <= nack_d;
      end
   end

endmodule

// File: tb/tb_i2c_word_writer.sv
// Bench for i2c_word_writer: a bus-level slave decodes SCL/SDA and acks per a mask.
module tb_i2c_word_writer;
   import i2c_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, go, go4;
   logic [23:0] data, data4;
   logic        done, busy, done4, busy4;
   logic [2:0]  nack, nack4;
   logic        scl, scl4;
   wire         sda, sda4;
   logic        slv_drv;
   logic [2:0]  slv_nack_mask;

   pullup (sda);
   pullup (sda4);
   assign sda = slv_drv ? 1'b0 : 1'bz;

   i2c_word_writer u_dut (
      .clk_i2c(clk), .reset(reset), .go(go), .data(data), .done(done), .busy(busy),
      .nack(nack), .i2c_sclk(scl), .i2c_sdat(sda)
   );

   i2c_word_writer #(.QUARTER_CYCLES(4)) u_dut4 (
      .clk_i2c(clk), .reset(reset), .go(go4), .data(data4), .done(done4), .busy(busy4),
      .nack(nack4), .i2c_sclk(scl4), .i2c_sdat(sda4)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Bus-level slave: bytes seen on SCL rises, ACK pulled low per mask.
   logic [7:0] rx_q[$];
   int         rises;
   initial begin
      logic [7:0] shreg;
      logic       s, d, scl_p, sda_p;
      slv_drv = 1'b0; rises = 0; shreg = '0; scl_p = 1'b1; sda_p = 1'b1;
      forever begin
         @(negedge clk);
         s = scl; d = sda;
         if (reset) begin
            rises = 0; slv_drv = 1'b0;
         end else begin
            if (s && scl_p && sda_p && !d) rises = 0;
            if (s && !scl_p) begin
               if (rises % 9 != 8) begin
                  shreg = {shreg[6:0], d};
                  rises++;
                  if (rises % 9 == 8) rx_q.push_back(shreg);
               end else begin
                  rises++;
               end
            end
            if (!s && scl_p) begin
               if (rises % 9 == 8) slv_drv = !slv_nack_mask[2 - (rises / 9)];
               else                slv_drv = 1'b0;
            end
         end
         scl_p = s; sda_p = d;
      end
   end

   function automatic int exp_nbytes(input logic [2:0] m);
      int n;
      n = 3;
`ifdef I2C_NACK_ABORT_EN
      if (m[2]) n = 1;
      else if (m[1]) n = 2;
`endif
      return n;
   endfunction

   function automatic int exp_done_qp(input logic [2:0] m);
      return 2 + 4 * 9 * exp_nbytes(m) + 3;
   endfunction

   function automatic logic [2:0] exp_nack(input logic [2:0] m);
      logic [2:0] r;
      r = m;
`ifdef I2C_NACK_ABORT_EN
      if (m[2]) r = 3'b100;
      else if (m[1]) r = 3'b010;
`endif
      return r;
   endfunction

   task automatic run_xfer(input logic [23:0] d, input logic [2:0] mask,
                           output int done_cyc, output logic busy_acc, output logic busy_dn);
      slv_nack_mask = mask;
      rx_q.delete();
      @(negedge clk); data = d; go = 1'b1;
      @(posedge clk); #1;
      busy_acc = busy;
      done_cyc = 0;
      while (!done && done_cyc < 2000) begin
         @(posedge clk); #1; done_cyc++;
      end
      busy_dn = busy;
      @(negedge clk); go = 1'b0; data = 24'($urandom);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; go = 1'b0; go4 = 1'b0; data = '0; data4 = '0; slv_nack_mask = '0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (scl !== 1'b1) begin n_bad++; $display("FAIL reset_scl: got %b expected 1", scl); end
      n_vec++; if (sda !== 1'b1) begin n_bad++; $display("FAIL reset_sda_released: got %b expected 1", sda); end
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
      n_vec++; if (nack !== 3'b000) begin n_bad++; $display("FAIL reset_nack: got %b expected 000", nack); end
      @(negedge clk); reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_no_go_busy: got %b expected 0", busy); end
   endtask

   task automatic test_known_word();
      logic [23:0] d;
      int          dc;
      logic        ba, bd;
      d = {WM8731_WR_ADDR, 8'h1E, 8'h00};
      run_xfer(d, 3'b000, dc, ba, bd);
      n_vec++; if (rx_q.size() != 3) begin n_bad++; $display("FAIL known_nbytes: got %0d expected 3", rx_q.size()); end
      for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
         n_vec++;
         if (rx_q[i] !== d[23 - 8 * i -: 8]) begin
            n_bad++; $display("FAIL known_byte%0d: got %h expected %h", i, rx_q[i], d[23 - 8 * i -: 8]);
         end
      end
      n_vec++; if (nack !== 3'b000) begin n_bad++; $display("FAIL known_nack: got %b expected 000", nack); end
      n_vec++; if (dc != 113) begin n_bad++; $display("FAIL known_done_clk: got %0d expected 113", dc); end
      n_vec++; if (ba !== 1'b1) begin n_bad++; $display("FAIL known_busy_accept: got %b expected 1", ba); end
      n_vec++; if (bd !== 1'b0) begin n_bad++; $display("FAIL known_busy_at_done: got %b expected 0", bd); end
      n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL known_idle_after: got %b expected 0", done); end
      n_vec++; if (sda !== 1'b1) begin n_bad++; $display("FAIL known_sda_idle: got %b expected 1", sda); end
   endtask

   task automatic test_nack_byte1();
      logic [23:0] d;
      int          dc;
      logic        ba, bd;
      d = 24'h34A55A;
      run_xfer(d, 3'b010, dc, ba, bd);
      n_vec++; if (nack !== exp_nack(3'b010)) begin n_bad++; $display("FAIL nack1_nack: got %b expected %b", nack, exp_nack(3'b010)); end
      n_vec++; if (dc != exp_done_qp(3'b010)) begin n_bad++; $display("FAIL nack1_done_clk: got %0d expected %0d", dc, exp_done_qp(3'b010)); end
      n_vec++; if (rises != 9 * exp_nbytes(3'b010) + 1) begin n_bad++; $display("FAIL nack1_scl_rises: got %0d expected %0d", rises, 9 * exp_nbytes(3'b010) + 1); end
      n_vec++; if (rx_q.size() != exp_nbytes(3'b010)) begin n_bad++; $display("FAIL nack1_nbytes: got %0d expected %0d", rx_q.size(), exp_nbytes(3'b010)); end
   endtask

   task automatic test_random_words();
      logic [23:0] d;
      logic [2:0]  m;
      int          dc, nb;
      logic        ba, bd;
      for (int t = 0; t < 8; t++) begin
         d = 24'($urandom);
         m = 3'($urandom_range(0, 7));
         nb = exp_nbytes(m);
         run_xfer(d, m, dc, ba, bd);
         n_vec++; if (nack !== exp_nack(m)) begin n_bad++; $display("FAIL rand%0d_nack: got %b expected %b", t, nack, exp_nack(m)); end
         n_vec++; if (dc != exp_done_qp(m)) begin n_bad++; $display("FAIL rand%0d_done_clk: got %0d expected %0d", t, dc, exp_done_qp(m)); end
         n_vec++; if (rx_q.size() != nb) begin n_bad++; $display("FAIL rand%0d_nbytes: got %0d expected %0d", t, rx_q.size(), nb); end
         for (int i = 0; i < nb && i < rx_q.size(); i++) begin
            n_vec++;
            if (rx_q[i] !== d[23 - 8 * i -: 8]) begin
               n_bad++; $display("FAIL rand%0d_byte%0d: got %h expected %h", t, i, rx_q[i], d[23 - 8 * i -: 8]);
            end
         end
      end
   endtask

   task automatic test_go_held();
      int   starts, bad;
      logic pb;
      slv_nack_mask = 3'b000;
      @(negedge clk); data = 24'($urandom); go = 1'b1;
      @(posedge clk); #1;
      starts = busy ? 1 : 0; pb = busy; bad = 0;
      for (int c = 1; c < 300; c++) begin
         @(posedge clk); #1;
         if (busy && !pb) starts++;
         pb = busy;
         if (done !== (c >= 113)) bad++;
      end
      n_vec++; if (starts != 1) begin n_bad++; $display("FAIL held_transfers: got %0d expected 1", starts); end
      n_vec++; if (bad != 0) begin n_bad++; $display("FAIL held_done_profile: got %0d bad cycles expected 0", bad); end
      @(negedge clk); go = 1'b0;
      @(posedge clk); #1;
      n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL held_release_done: got %b expected 0", done); end
      @(posedge clk); #1;
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL held_release_busy: got %b expected 0", busy); end
   endtask

   task automatic test_data_change();
      logic [23:0] d;
      int          dc;
      d = 24'($urandom);
      slv_nack_mask = 3'b000;
      rx_q.delete();
      @(negedge clk); data = d; go = 1'b1;
      @(posedge clk); #1;
      dc = 0;
      while (!done && dc < 2000) begin
         @(posedge clk); #1; dc++;
         if (dc == 20) data = ~d;
         if (dc == 30) go = 1'b0;
         if (dc == 31) go = 1'b1;
      end
      n_vec++; if (dc != 113) begin n_bad++; $display("FAIL chg_done_clk: got %0d expected 113", dc); end
      n_vec++; if (rx_q.size() != 3) begin n_bad++; $display("FAIL chg_nbytes: got %0d expected 3", rx_q.size()); end
      for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
         n_vec++;
         if (rx_q[i] !== d[23 - 8 * i -: 8]) begin
            n_bad++; $display("FAIL chg_byte%0d: got %h expected %h", i, rx_q[i], d[23 - 8 * i -: 8]);
         end
      end
      @(negedge clk); go = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      logic [23:0] d;
      int          dc;
      d = 24'h340055;
      slv_nack_mask = 3'b000;
      @(negedge clk); data = d; go = 1'b1;
      @(posedge clk);
      repeat (50) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      n_vec++; if (scl !== 1'b1) begin n_bad++; $display("FAIL midrst_scl: got %b expected 1", scl); end
      n_vec++; if (sda !== 1'b1) begin n_bad++; $display("FAIL midrst_sda: got %b expected 1", sda); end
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      @(posedge clk);
      @(negedge clk); reset = 1'b0; rx_q.delete();
      @(posedge clk); #1;
      n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midrst_reaccept: got %b expected 1", busy); end
      dc = 0;
      while (!done && dc < 2000) begin
         @(posedge clk); #1; dc++;
      end
      n_vec++; if (dc != 113) begin n_bad++; $display("FAIL midrst_done_clk: got %0d expected 113", dc); end
      n_vec++; if (rx_q.size() != 3) begin n_bad++; $display("FAIL midrst_nbytes: got %0d expected 3", rx_q.size()); end
      for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
         n_vec++;
         if (rx_q[i] !== d[23 - 8 * i -: 8]) begin
            n_bad++; $display("FAIL midrst_byte%0d: got %h expected %h", i, rx_q[i], d[23 - 8 * i -: 8]);
         end
      end
      @(negedge clk); go = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_quarter4();
      int   dc, first, second;
      logic pscl;
      @(negedge clk); data4 = 24'($urandom); go4 = 1'b1;
      @(posedge clk); #1;
      dc = 0; first = -1; second = -1; pscl = scl4;
      while (!done4 && dc < 4000) begin
         @(posedge clk); #1; dc++;
         if (scl4 && !pscl) begin
            if (first < 0) first = dc;
            else if (second < 0) second = dc;
         end
         pscl = scl4;
      end
      n_vec++; if (second - first != 16) begin n_bad++; $display("FAIL qc4_scl_period: got %0d expected 16", second - first); end
      n_vec++; if (dc != 4 * exp_done_qp(3'b111)) begin n_bad++; $display("FAIL qc4_done_clk: got %0d expected %0d", dc, 4 * exp_done_qp(3'b111)); end
      n_vec++; if (nack4 !== exp_nack(3'b111)) begin n_bad++; $display("FAIL qc4_nack: got %b expected %b", nack4, exp_nack(3'b111)); end
      @(negedge clk); go4 = 1'b0;
      @(posedge clk); #1;
      n_vec++; if (done4 !== 1'b0) begin n_bad++; $display("FAIL qc4_release_done: got %b expected 0", done4); end
   endtask

   initial begin
      test_reset();
      test_known_word();
      test_nack_byte1();
      test_random_words();
      test_go_held();
      test_data_change();
      test_reset_mid();
      test_quarter4();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/i2c_word_writer.md
I2C_WORD_WRITER -- requirements
Module: i2c_word_writer

Interface
REQ-001 SHALL have parameter QUARTER_CYCLES, default 1: clk_i2c cycles per SCL quarter-phase (legal 1..255).
REQ-002 SHALL have port clk_i2c, input, 1: sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port go, input, 1: transfer request, level-held by requester until done seen.
REQ-005 SHALL have port data, input, 24: {slave_addr_rw, sub_addr, payload}, sent MSB first.
REQ-006 SHALL have port done, output, 1: transfer complete, held until go low.
REQ-007 SHALL have port busy, output, 1: high from accept until done rises.
REQ-008 SHALL have port nack, output, 3: per-byte not-acknowledged flags; nack[2]=byte 0 (address), nack[0]=byte 2.
REQ-009 SHALL have port i2c_sclk, output, 1: I2C clock, push-pull.
REQ-010 SHALL have port i2c_sdat, inout, 1: I2C data, open-drain (drive 0 or Z only, never 1).

Function
REQ-011 SHALL use the FSM states IDLE, START, BIT, STOP, DONE; times below are in quarter-phases (QP = QUARTER_CYCLES clocks).
REQ-012 SHALL, in IDLE, hold i2c_sclk=1 and i2c_sdat=Z, and accept when go=1 and done=0.
REQ-013 SHALL, on accept, latch data into a shift register, clear nack to 000, raise busy, and enter START.
REQ-014 SHALL, in START, spend 2 QP: QP0 SDA=0/SCL=1; QP1 SDA=0/SCL=0.
REQ-015 SHALL send 27 bit slots (8 data + 1 ACK per byte) of 4 QP each: q0 SCL=0 with SDA set up; q1 and q2 SCL=1; q3 SCL=0.
REQ-016 SHALL drive SDA to Z for a 1 bit and 0 for a 0 bit in data slots, and release SDA (Z) during ACK slots.
REQ-017 SHALL sample i2c_sdat at the last clock of q2 in each ACK slot and set that byte's nack bit if the sampled value is 1.
REQ-018 SHALL, in STOP, spend 3 QP: QP0 SDA=0/SCL=0; QP1 SDA=0/SCL=1; QP2 SDA=Z/SCL=1.
REQ-019 SHALL, after STOP, enter DONE with done=1 and busy=0; done rises exactly 113 QP after the accept edge (at default QUARTER_CYCLES=1: 113 clocks).
REQ-020 SHALL remain in DONE while go=1 and return to IDLE with done=0 on the first cycle go=0; a new accept requires go low for at least one cycle.
REQ-021 SHALL ignore changes on go and data while busy=1.
REQ-022 SHALL hold nack stable from DONE until the next accept.
REQ-023 SHALL implement the quarter-phase divider as a counter that wraps at QUARTER_CYCLES-1, with its wrap as the only FSM advance strobe.

Reset
REQ-024 SHALL, on reset assertion and regardless of state, immediately force IDLE, i2c_sclk=1, i2c_sdat=Z, done=0, busy=0, nack=000, and clear the divider and bit counter.
REQ-025 SHALL, after reset deassertion, accept a go already held high on the first clock edge.

Configuration
REQ-026 SHALL, with I2C_NACK_ABORT_EN defined, finish the current ACK slot (q3) on any NACK, skip remaining bytes, and enter STOP; byte k NACK gives done at 2+9(k+1)*4+3 QP.
REQ-027 SHALL, without I2C_NACK_ABORT_EN, always send all 3 bytes and record every NACK.

Structure
REQ-028 SHALL place the state encoding, FRAME_SLOTS=27, START_QP=2, STOP_QP=3, and WM8731_WR_ADDR=8'h34 in shared package i2c_pkg.
REQ-029 SHALL contain exactly one sub-module, i2c_qphase_gen (quarter-phase divider plus 2-bit quarter index).

Verification
REQ-030 SHALL verify: data=24'h341E00 with the slave ACKing all bytes -> SDA decodes 0x34, 0x1E, 0x00; nack=000; done at clock 113.
REQ-031 SHALL verify: slave NACKs byte 1, macro undefined -> nack=010, done at clock 113; macro defined -> nack=010, done at clock 77, with no byte 2 clocked.
REQ-032 SHALL verify: go held high for 300 clocks -> exactly one transfer, done high from clock 113 until go falls, then IDLE next cycle.
REQ-033 SHALL verify: reset asserted at clock 50 mid-byte -> same-cycle SCL=1, SDA=Z, busy=0; a go after release restarts from START.
REQ-034 SHALL verify: data changed at clock 20 mid-transfer -> bytes on the wire still match the value latched at accept.
REQ-035 SHALL verify: QUARTER_CYCLES=4 -> SCL period 16 clocks, done at clock 452.
